// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory responder for the LSU: fixed-latency FSM, byte-lane writes, raw word reads.
// Optional out-of-range detection is enabled with `define DMEM_CTRL_RANGE_CHECK_EN.
module dmem_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [3:0]      req_byte_en,
  input  logic            req_wr_en,
  input  logic            req_rd_en,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_valid,
  output logic            resp_err,
  output logic            mem_stall
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [3:0]      be_q;
  logic            wr_q;
  logic [XLEN-1:0] rdata_q;

  logic            req_active;
  logic            latch;
  logic            access;
  logic [XLEN-1:0] acc_addr, acc_wdata;
  logic [3:0]      acc_be;
  logic            acc_wr;
  logic [IdxW-1:0] acc_idx;
  logic            acc_oor;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  assign req_active = req_rd_en | req_wr_en;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    latch      = 1'b0;
    access     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_active) begin
          latch      = 1'b1;
          wait_cnt_d = 4'(LATENCY);
          if (LATENCY > 0) begin
            state_d = StWait;
          end else begin
            access  = 1'b1;
            state_d = StResp;
          end
        end
      end
      StWait: begin
        // Access fires on the edge where the count leaves 1.
        if (wait_cnt_q <= 4'd1) begin
          access     = 1'b1;
          wait_cnt_d = 4'd0;
          state_d    = StResp;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // With zero latency the access happens in IDLE, straight from the request inputs.
  always_comb begin
    if (state_q == StIdle) begin
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_byte_en;
      acc_wr    = req_wr_en;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
      acc_wr    = wr_q;
    end
  end

  assign acc_idx = acc_addr[IdxW+1:2];

`ifdef DMEM_CTRL_RANGE_CHECK_EN
  logic err_q;
  logic unused_addr;

  assign acc_oor     = |acc_addr[XLEN-1:IdxW+2];
  assign unused_addr = ^acc_addr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (access) begin
      err_q <= acc_oor;
    end
  end

  assign resp_err = err_q & resp_valid;
`else
  logic unused_addr;

  assign acc_oor     = 1'b0;
  assign unused_addr = ^{acc_addr[XLEN-1:IdxW+2], acc_addr[1:0]};
  assign resp_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 4'd0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (latch) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_byte_en;
        wr_q    <= req_wr_en;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (access && !acc_wr) begin
      rdata_q <= acc_oor ? '0 : mem[acc_idx];
    end
  end

  // Backing array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (access && acc_wr && !acc_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) begin
          mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_valid = (state_q == StResp);
  assign mem_stall  = req_active & ~resp_valid;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: LATENCY=2 main instance plus a LATENCY=0 instance,
// checked against a word-array reference model with randomized traffic.
module tb_dmem_ctrl;

  localparam int unsigned Lat = 2;

  logic        clk = 1'b0;
  logic        reset;

  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [3:0]  req_byte_en;
  logic        req_wr_en, req_rd_en, resp_valid, resp_err, mem_stall;

  logic [31:0] z_addr, z_wdata, z_rdata;
  logic [3:0]  z_byte_en;
  logic        z_wr_en, z_rd_en, z_valid, z_err, z_stall;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] model_mem [1024];
  logic [31:0] model_last;

  always #5 clk = ~clk;

  dmem_ctrl #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(Lat)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_byte_en(req_byte_en),
    .req_wr_en  (req_wr_en),
    .req_rd_en  (req_rd_en),
    .resp_rdata (resp_rdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .mem_stall  (mem_stall)
  );

  dmem_ctrl #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(0)) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .req_addr   (z_addr),
    .req_wdata  (z_wdata),
    .req_byte_en(z_byte_en),
    .req_wr_en  (z_wr_en),
    .req_rd_en  (z_rd_en),
    .resp_rdata (z_rdata),
    .resp_valid (z_valid),
    .resp_err   (z_err),
    .mem_stall  (z_stall)
  );

  // One full transaction on the main instance; starts and ends exactly on a negedge in IDLE.
  task automatic tx(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                    input logic rd, input logic wr, input string name);
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [9:0]  idx;
    int          cyc;
    int          stall_cyc;
    idx     = addr[11:2];
    exp_err = 1'b0;
`ifdef DMEM_CTRL_RANGE_CHECK_EN
    if (addr >= 32'h1000) exp_err = 1'b1;
`endif
    if (wr) begin
      if (!exp_err) begin
        for (int b = 0; b < 4; b++) if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end
      exp_rdata = model_last;
    end else begin
      exp_rdata  = exp_err ? 32'h0 : model_mem[idx];
      model_last = exp_rdata;
    end
    req_addr = addr; req_wdata = wdata; req_byte_en = be; req_rd_en = rd; req_wr_en = wr;
    #1;
    cyc = 0;
    stall_cyc = mem_stall ? 1 : 0;
    while (!resp_valid && cyc < 20) begin
      @(negedge clk); #1;
      cyc++;
      if (mem_stall) stall_cyc++;
    end
    n_cmp++;
    if (!resp_valid) begin
      n_bad++;
      $display("FAIL %s timeout: resp_valid not seen after %0d cycles", name, cyc);
    end else begin
      if (cyc != Lat + 1) begin
        n_bad++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, Lat + 1);
      end
      n_cmp++;
      if (stall_cyc != Lat + 1) begin
        n_bad++; $display("FAIL %s stall: got %0d expected %0d", name, stall_cyc, Lat + 1);
      end
      n_cmp++;
      if (resp_rdata !== exp_rdata) begin
        n_bad++; $display("FAIL %s rdata: got %h expected %h", name, resp_rdata, exp_rdata);
      end
      n_cmp++;
      if (resp_err !== exp_err) begin
        n_bad++; $display("FAIL %s err: got %b expected %b", name, resp_err, exp_err);
      end
    end
    req_rd_en = 1'b0; req_wr_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({resp_valid, resp_err, mem_stall} !== 3'b000 || resp_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset main: valid/err/stall=%b%b%b rdata=%h expected 000 0", resp_valid,
               resp_err, mem_stall, resp_rdata);
    end
    n_cmp++;
    if ({z_valid, z_err, z_stall} !== 3'b000 || z_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset lat0: valid/err/stall=%b%b%b rdata=%h expected 000 0", z_valid, z_err,
               z_stall, z_rdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    tx(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, "basic_wr");
    tx(32'h10, 32'h0, 4'h0, 1'b1, 1'b0, "basic_rd");
  endtask

  task automatic test_partial();
    tx(32'h10, 32'h0000AA00, 4'b0010, 1'b0, 1'b1, "partial_wr");
    tx(32'h10, 32'h0, 4'h0, 1'b1, 1'b0, "partial_rd");
    n_cmp++;
    if (model_mem[4] !== 32'hDEADAAEF) begin
      n_bad++; $display("FAIL partial model: got %h expected deadaaef", model_mem[4]);
    end
  endtask

  task automatic test_latency0();
    logic [31:0] pat [2];
    pat[0] = 32'hA5A50F0F;
    pat[1] = 32'h5A5AF0F0;
    for (int k = 0; k < 4; k++) begin
      z_addr = 32'h8 + 32'(k[0]) * 4; z_wdata = pat[k[0]]; z_byte_en = 4'hF;
      z_wr_en = (k < 2); z_rd_en = (k >= 2);
      #1;
      n_cmp++;
      if (z_stall !== 1'b1 || z_valid !== 1'b0) begin
        n_bad++; $display("FAIL lat0 accept %0d: stall=%b valid=%b expected 1 0", k, z_stall,
                          z_valid);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (z_valid !== 1'b1 || z_stall !== 1'b0) begin
        n_bad++; $display("FAIL lat0 resp %0d: valid=%b stall=%b expected 1 0", k, z_valid,
                          z_stall);
      end
      if (k >= 2) begin
        n_cmp++;
        if (z_rdata !== pat[k[0]]) begin
          n_bad++; $display("FAIL lat0 rdata %0d: got %h expected %h", k, z_rdata, pat[k[0]]);
        end
      end
      z_wr_en = 1'b0; z_rd_en = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_strobes();
    tx(32'h10, 32'h0, 4'h0, 1'b1, 1'b0, "strobe_pre_rd");
    tx(32'h30, 32'h5, 4'hF, 1'b1, 1'b1, "strobe_both");
    tx(32'h30, 32'h0, 4'h0, 1'b1, 1'b0, "strobe_rd");
  endtask

  task automatic test_reset_midop();
    tx(32'h20, 32'h0, 4'hF, 1'b0, 1'b1, "midop_init");
    tx(32'h10, 32'h0, 4'h0, 1'b1, 1'b0, "midop_pre_rd");
    req_addr = 32'h20; req_wdata = 32'h12345678; req_byte_en = 4'hF;
    req_wr_en = 1'b1; req_rd_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      n_bad++; $display("FAIL midop reset: valid=%b err=%b rdata=%h expected 0 0 0", resp_valid,
                        resp_err, resp_rdata);
    end
    model_last = 32'h0;
    req_wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_bad++; $display("FAIL midop spurious: resp_valid=%b expected 0", resp_valid);
    end
    tx(32'h20, 32'h0, 4'h0, 1'b1, 1'b0, "midop_rd");
  endtask

  task automatic test_range();
    tx(32'h0, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1, "range_wr0");
    tx(32'h1000, 32'h0, 4'h0, 1'b1, 1'b0, "range_rd");
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          op;
    for (int w = 0; w < 16; w++) tx(32'h100 + 32'(w) * 4, $urandom, 4'hF, 1'b0, 1'b1, "rnd_init");
    for (int i = 0; i < 40; i++) begin
      a  = 32'h100 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      op = $urandom_range(0, 2);
      tx(a, $urandom, 4'($urandom_range(0, 15)), op != 1, op != 0, "rnd_op");
    end
  endtask

  // Request stays asserted through RESP; the next one is taken only after an IDLE cycle.
  task automatic test_back_to_back();
    logic [31:0] a [3];
    logic [31:0] exp_rdata;
    int          cyc;
    a[0] = 32'h10; a[1] = 32'h30; a[2] = 32'h104;
    req_rd_en = 1'b1; req_wr_en = 1'b0; req_byte_en = 4'h0; req_addr = a[0];
    #1;
    for (int k = 0; k < 3; k++) begin
      cyc = 0;
      if (k > 0) begin
        @(negedge clk); #1;
        cyc = 1;
      end
      while (!resp_valid && cyc < 20) begin
        @(negedge clk); #1;
        cyc++;
      end
      n_cmp++;
      if (cyc != ((k == 0) ? Lat + 1 : Lat + 2)) begin
        n_bad++; $display("FAIL b2b spacing %0d: got %0d expected %0d", k, cyc,
                          (k == 0) ? Lat + 1 : Lat + 2);
      end
      exp_rdata  = model_mem[a[k][11:2]];
      model_last = exp_rdata;
      n_cmp++;
      if (resp_rdata !== exp_rdata) begin
        n_bad++; $display("FAIL b2b rdata %0d: got %h expected %h", k, resp_rdata, exp_rdata);
      end
      if (k < 2) req_addr = a[k+1];
    end
    req_rd_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_addr = '0; req_wdata = '0; req_byte_en = '0; req_wr_en = 1'b0; req_rd_en = 1'b0;
    z_addr = '0; z_wdata = '0; z_byte_en = '0; z_wr_en = 1'b0; z_rd_en = 1'b0;
    model_last = 32'h0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_partial();
    test_latency0();
    test_strobes();
    test_reset_midop();
    test_range();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
